// File: rtl/rrat_commit.sv
// Retirement register alias table (RRAT).
// Retires up to N destination writes per cycle into the committed
// architectural-to-physical map, maintains the committed free list and its
// popcount, and emits a one-cycle pulse of physical registers superseded by
// the retirement, for the RAT/PRF to reclaim.
// Optional macro RRAT_CHECK_EN: enables a sticky consistency error flag for
// retirements of PRF 0 or of a physical register that is not free.
module rrat_commit #(
    parameter int N                  = 3,
    parameter int RAT_SIZE           = 32,
    parameter int PRF_NUM_ENTRIES    = 64,
    parameter int REG_INDEX_BITS     = $clog2(RAT_SIZE),
    parameter int PRF_NUM_INDEX_BITS = $clog2(PRF_NUM_ENTRIES)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [N-1:0]                           retire_valid,
    input  logic [N*REG_INDEX_BITS-1:0]            retire_arch_reg,
    input  logic [N*PRF_NUM_INDEX_BITS-1:0]        retire_phys_reg,
    output logic [RAT_SIZE*PRF_NUM_INDEX_BITS-1:0] rrat_entries,
    output logic [PRF_NUM_ENTRIES-1:0]             rrat_free_list,
    output logic [PRF_NUM_ENTRIES-1:0]             free_vector_from_rrat,
    output logic [PRF_NUM_INDEX_BITS:0]            rrat_free_count,
    output logic                                   rrat_error
);

    logic [PRF_NUM_INDEX_BITS-1:0] map_q [RAT_SIZE];
    logic [PRF_NUM_INDEX_BITS-1:0] map_d [RAT_SIZE];
    logic [PRF_NUM_ENTRIES-1:0]    free_q, free_d;
    logic [PRF_NUM_ENTRIES-1:0]    pulse_q, pulse_d;
    logic [PRF_NUM_INDEX_BITS:0]   count_q, count_d;
    logic [N-1:0]                  slotEff;

    // A slot only matters when it is valid and does not target x0.
    always_comb begin
        slotEff = '0;
        for (int i = 0; i < N; i++) begin
            slotEff[i] = retire_valid[i] &&
                         (retire_arch_reg[i*REG_INDEX_BITS +: REG_INDEX_BITS] != '0);
        end
    end

    // Walk the slots in program order so a later slot to the same arch reg
    // sees (and frees) the physical register written by an earlier slot.
    always_comb begin : update_comb
        logic [REG_INDEX_BITS-1:0]     arch;
        logic [PRF_NUM_INDEX_BITS-1:0] phys;
        logic [PRF_NUM_INDEX_BITS-1:0] old;
        arch    = '0;
        phys    = '0;
        old     = '0;
        map_d   = map_q;
        free_d  = free_q;
        pulse_d = '0;
        for (int i = 0; i < N; i++) begin
            arch = retire_arch_reg[i*REG_INDEX_BITS +: REG_INDEX_BITS];
            phys = retire_phys_reg[i*PRF_NUM_INDEX_BITS +: PRF_NUM_INDEX_BITS];
            if (slotEff[i]) begin
                old          = map_d[arch];
                map_d[arch]  = phys;
                free_d[phys] = 1'b0;
                if (old != '0) begin
                    free_d[old]  = 1'b1;
                    pulse_d[old] = 1'b1;
                end
            end
        end
        // PRF 0 is the hardwired zero register and is never reclaimable.
        free_d[0]  = 1'b0;
        pulse_d[0] = 1'b0;
    end

    // Popcount of the next free list so the registered count never lags.
    always_comb begin
        count_d = '0;
        for (int p = 0; p < PRF_NUM_ENTRIES; p++) begin
            count_d = count_d + {{PRF_NUM_INDEX_BITS{1'b0}}, free_d[p]};
        end
    end

    // Committed state registers; reset restores the boot-time mapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < RAT_SIZE; a++) begin
                map_q[a] <= '0;
            end
            free_q  <= {{(PRF_NUM_ENTRIES-1){1'b1}}, 1'b0};
            pulse_q <= '0;
            count_q <= (PRF_NUM_INDEX_BITS+1)'(PRF_NUM_ENTRIES-1);
        end else begin
            for (int a = 0; a < RAT_SIZE; a++) begin
                map_q[a] <= map_d[a];
            end
            free_q  <= free_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    for (genvar g = 0; g < RAT_SIZE; g++) begin : g_entries
        assign rrat_entries[g*PRF_NUM_INDEX_BITS +: PRF_NUM_INDEX_BITS] = map_q[g];
    end

    assign rrat_free_list        = free_q;
    assign free_vector_from_rrat = pulse_q;
    assign rrat_free_count       = count_q;

`ifdef RRAT_CHECK_EN
    logic errFlag_q, errFlag_d;

    // Flag retirement of PRF 0, or of a register that was not free before
    // this cycle unless an earlier slot this cycle already claimed it.
    always_comb begin : check_comb
        logic                          earlier;
        logic [PRF_NUM_INDEX_BITS-1:0] phys;
        earlier   = 1'b0;
        phys      = '0;
        errFlag_d = errFlag_q;
        for (int i = 0; i < N; i++) begin
            phys    = retire_phys_reg[i*PRF_NUM_INDEX_BITS +: PRF_NUM_INDEX_BITS];
            earlier = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (k < i && slotEff[k] &&
                    retire_phys_reg[k*PRF_NUM_INDEX_BITS +: PRF_NUM_INDEX_BITS] == phys) begin
                    earlier = 1'b1;
                end
            end
            if (slotEff[i]) begin
                if (phys == '0) begin
                    errFlag_d = 1'b1;
                end else if (!free_q[phys] && !earlier) begin
                    errFlag_d = 1'b1;
                end
            end
        end
    end

    // Sticky error register, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            errFlag_q <= 1'b0;
        end else begin
            errFlag_q <= errFlag_d;
        end
    end

    assign rrat_error = errFlag_q;
`else
    assign rrat_error = 1'b0;
`endif

endmodule

// File: tb/tb_rrat_commit.sv
// Self-checking bench for rrat_commit: directed scenarios plus randomized
// retirement traffic against a behavioural model of the committed map.
module tb_rrat_commit;

    logic         clock;
    logic         reset;
    logic [2:0]   retire_valid;
    logic [14:0]  retire_arch_reg;
    logic [17:0]  retire_phys_reg;
    logic [191:0] rrat_entries;
    logic [63:0]  rrat_free_list;
    logic [63:0]  free_vector_from_rrat;
    logic [6:0]   rrat_free_count;
    logic         rrat_error;

    int compared;
    int mismatched;

    // Behavioural model of the committed state.
    int       mMap [32];
    bit [63:0] mFree;
    bit [63:0] mPulse;
    bit        mErr;

    rrat_commit dut (
        .clock                 (clock),
        .reset                 (reset),
        .retire_valid          (retire_valid),
        .retire_arch_reg       (retire_arch_reg),
        .retire_phys_reg       (retire_phys_reg),
        .rrat_entries          (rrat_entries),
        .rrat_free_list        (rrat_free_list),
        .free_vector_from_rrat (free_vector_from_rrat),
        .rrat_free_count       (rrat_free_count),
        .rrat_error            (rrat_error)
    );

    // 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Put the model back into its boot state.
    task automatic modelReset();
        for (int a = 0; a < 32; a++) mMap[a] = 0;
        mFree  = ~64'h1;
        mPulse = '0;
        mErr   = 1'b0;
    endtask

    function automatic logic [191:0] expEntries();
        logic [191:0] v;
        v = '0;
        for (int a = 0; a < 32; a++) v[a*6 +: 6] = 6'(mMap[a]);
        return v;
    endfunction

    function automatic logic [6:0] expCount();
        return 7'($countones(mFree));
    endfunction

    // Retire one group of slots through the model: list semantics in
    // program order, a superseded mapping returns its register to the pool.
    task automatic modelRetire(input logic [2:0] v, input logic [14:0] a, input logic [17:0] p);
        int   arch, phys, old;
        bit [63:0] freeBefore;
        int   claimed [$];
        freeBefore = mFree;
        mPulse = '0;
        for (int i = 0; i < 3; i++) begin
            arch = int'(a[i*5 +: 5]);
            phys = int'(p[i*6 +: 6]);
            if (v[i] && arch != 0) begin
`ifdef RRAT_CHECK_EN
                if (phys == 0) mErr = 1'b1;
                else if (!freeBefore[phys] && !(phys inside {claimed})) mErr = 1'b1;
`endif
                claimed.push_back(phys);
                old = mMap[arch];
                mMap[arch] = phys;
                mFree[phys] = 1'b0;
                if (old != 0) begin
                    mFree[old]  = 1'b1;
                    mPulse[old] = 1'b1;
                end
            end
        end
        mFree[0]  = 1'b0;
        mPulse[0] = 1'b0;
    endtask

    // Drive a slot group after the falling edge, let one rising edge update
    // DUT and model, and return at the next falling edge for sampling.
    task automatic applyStimulus(input logic [2:0] v, input logic [14:0] a, input logic [17:0] p);
        retire_valid    = v;
        retire_arch_reg = a;
        retire_phys_reg = p;
        modelRetire(v, a, p);
        @(posedge clock);
        @(negedge clock);
        retire_valid = '0;
    endtask

    task automatic idleCycle();
        applyStimulus(3'b000, '0, '0);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        #2;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) idleCycle();
            if (rrat_entries !== 192'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_map: got %h expected 0", rrat_entries);
            end
            compared++;
            if (rrat_free_list !== ~64'h1) begin
                mismatched++;
                $display("[TB] FAIL reset_free: got %h expected %h", rrat_free_list, ~64'h1);
            end
            compared++;
            if (rrat_free_count !== 7'd63) begin
                mismatched++;
                $display("[TB] FAIL reset_count: got %0d expected 63", rrat_free_count);
            end
            compared++;
            if (free_vector_from_rrat !== 64'h0 || rrat_error !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_pulse_err: got %h/%b expected 0/0", free_vector_from_rrat, rrat_error);
            end
            compared++;
        end
    endtask

    task automatic test_single();
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd5}, {6'd0, 6'd0, 6'd7});
        if (rrat_entries[5*6 +: 6] !== 6'd7 || rrat_free_list[7] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_map: got x5=%0d free7=%b expected 7/0", rrat_entries[5*6 +: 6], rrat_free_list[7]);
        end
        compared++;
        if (rrat_free_count !== 7'd62 || free_vector_from_rrat !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL single_count: got %0d/%h expected 62/0", rrat_free_count, free_vector_from_rrat);
        end
        compared++;
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd5}, {6'd0, 6'd0, 6'd9});
        if (rrat_entries[5*6 +: 6] !== 6'd9 || free_vector_from_rrat !== (64'h1 << 7)) begin
            mismatched++;
            $display("[TB] FAIL replace_pulse: got x5=%0d pulse=%h expected 9/%h", rrat_entries[5*6 +: 6], free_vector_from_rrat, 64'h1 << 7);
        end
        compared++;
        if (rrat_free_count !== 7'd62 || rrat_free_list !== mFree) begin
            mismatched++;
            $display("[TB] FAIL replace_free: got %0d/%h expected 62/%h", rrat_free_count, rrat_free_list, mFree);
        end
        compared++;
        idleCycle();
        if (free_vector_from_rrat !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL pulse_one_cycle: got %h expected 0", free_vector_from_rrat);
        end
        compared++;
    endtask

    task automatic test_chain();
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd3}, {6'd0, 6'd0, 6'd4});
        applyStimulus(3'b011, {5'd0, 5'd3, 5'd3}, {6'd0, 6'd11, 6'd10});
        if (rrat_entries[3*6 +: 6] !== 6'd11 || free_vector_from_rrat !== ((64'h1 << 4) | (64'h1 << 10))) begin
            mismatched++;
            $display("[TB] FAIL chain_map_pulse: got x3=%0d pulse=%h expected 11/%h", rrat_entries[3*6 +: 6], free_vector_from_rrat, (64'h1 << 4) | (64'h1 << 10));
        end
        compared++;
        if (rrat_free_list[4] !== 1'b1 || rrat_free_list[10] !== 1'b1 || rrat_free_list[11] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL chain_free: got b4=%b b10=%b b11=%b expected 1/1/0", rrat_free_list[4], rrat_free_list[10], rrat_free_list[11]);
        end
        compared++;
        if (rrat_free_count !== expCount()) begin
            mismatched++;
            $display("[TB] FAIL chain_count: got %0d expected %0d", rrat_free_count, expCount());
        end
        compared++;
    endtask

    task automatic test_arch0();
        logic [191:0] mapBefore;
        logic [63:0]  freeBefore;
        logic [6:0]   countBefore;
        idleCycle();
        mapBefore   = expEntries();
        freeBefore  = mFree;
        countBefore = expCount();
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'd12});
        if (rrat_entries !== mapBefore || rrat_free_list !== freeBefore) begin
            mismatched++;
            $display("[TB] FAIL arch0_state: got free=%h expected %h", rrat_free_list, freeBefore);
        end
        compared++;
        if (rrat_free_count !== countBefore || free_vector_from_rrat !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL arch0_count: got %0d/%h expected %0d/0", rrat_free_count, free_vector_from_rrat, countBefore);
        end
        compared++;
    endtask

    task automatic test_full_width();
        doReset();
        applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {6'd22, 6'd21, 6'd20});
        if (rrat_free_count !== 7'd60 || free_vector_from_rrat !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL full_count: got %0d/%h expected 60/0", rrat_free_count, free_vector_from_rrat);
        end
        compared++;
        if (rrat_entries !== expEntries()) begin
            mismatched++;
            $display("[TB] FAIL full_map: got %h expected %h", rrat_entries, expEntries());
        end
        compared++;
        // Reset in the middle of a cycle with retirements pending.
        retire_valid    = 3'b111;
        retire_arch_reg = {5'd6, 5'd5, 5'd4};
        retire_phys_reg = {6'd32, 6'd31, 6'd30};
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        if (rrat_entries !== 192'h0 || rrat_free_list !== ~64'h1 || rrat_free_count !== 7'd63) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got free=%h count=%0d expected %h/63", rrat_free_list, rrat_free_count, ~64'h1);
        end
        compared++;
        @(negedge clock);
        retire_valid = '0;
        reset = 1'b1;
        idleCycle();
        if (rrat_entries !== 192'h0 || rrat_free_count !== 7'd63 || free_vector_from_rrat !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_discard: got count=%0d pulse=%h expected 63/0", rrat_free_count, free_vector_from_rrat);
        end
        compared++;
    endtask

    task automatic test_check();
        bit expErr;
`ifdef RRAT_CHECK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        doReset();
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd5}, {6'd0, 6'd0, 6'd7});
        if (rrat_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL check_clean: got %b expected 0", rrat_error);
        end
        compared++;
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd6}, {6'd0, 6'd0, 6'd7});
        if (rrat_error !== expErr || rrat_entries[6*6 +: 6] !== 6'd7) begin
            mismatched++;
            $display("[TB] FAIL check_flag: got err=%b x6=%0d expected %b/7", rrat_error, rrat_entries[6*6 +: 6], expErr);
        end
        compared++;
        idleCycle();
        idleCycle();
        if (rrat_error !== expErr) begin
            mismatched++;
            $display("[TB] FAIL check_sticky: got %b expected %b", rrat_error, expErr);
        end
        compared++;
        doReset();
        if (rrat_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL check_reset: got %b expected 0", rrat_error);
        end
        compared++;
    endtask

    task automatic test_random();
        logic [2:0]  v;
        logic [14:0] a;
        logic [17:0] p;
        doReset();
        for (int c = 0; c < 300; c++) begin
            v = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                // Narrow arch range to provoke same-cycle chaining.
                a[i*5 +: 5] = 5'($urandom_range(0, 7));
                p[i*6 +: 6] = 6'($urandom_range(1, 63));
            end
            applyStimulus(v, a, p);
            if (rrat_entries !== expEntries()) begin
                mismatched++;
                $display("[TB] FAIL rand_map c=%0d: got %h expected %h", c, rrat_entries, expEntries());
            end
            compared++;
            if (rrat_free_list !== mFree) begin
                mismatched++;
                $display("[TB] FAIL rand_free c=%0d: got %h expected %h", c, rrat_free_list, mFree);
            end
            compared++;
            if (free_vector_from_rrat !== mPulse) begin
                mismatched++;
                $display("[TB] FAIL rand_pulse c=%0d: got %h expected %h", c, free_vector_from_rrat, mPulse);
            end
            compared++;
            if (rrat_free_count !== expCount() || rrat_error !== mErr) begin
                mismatched++;
                $display("[TB] FAIL rand_count_err c=%0d: got %0d/%b expected %0d/%b", c, rrat_free_count, rrat_error, expCount(), mErr);
            end
            compared++;
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        compared        = 0;
        mismatched      = 0;
        retire_valid    = '0;
        retire_arch_reg = '0;
        retire_phys_reg = '0;
        reset           = 1'b0;
        modelReset();
        #12;
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_single();
        test_chain();
        test_arch0();
        test_full_width();
        test_check();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rrat_commit.md
Name: rrat_commit

Overview:
- Retirement register alias table (RRAT): the commit-side counterpart of the front-end RAT.
- Takes up to N retiring instructions per cycle, each carrying an architectural destination and the physical register allocated at rename.
- Updates the architectural-to-physical committed map.
- Produces the committed free list, and a one-cycle free pulse vector that the RAT and PRF use to reclaim superseded physical registers.
- On a nuke, the RAT reloads its map and free list from this block's registered outputs.

Parameters:
N, 3, retire width (slots per cycle)
RAT_SIZE, 32, architectural registers
PRF_NUM_ENTRIES, 64, physical registers
REG_INDEX_BITS, $clog2(RAT_SIZE), arch index width
PRF_NUM_INDEX_BITS, $clog2(PRF_NUM_ENTRIES), phys index width

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- retire_valid  in  N  slot i retiring with a destination write this cycle.
- retire_arch_reg  in  N x REG_INDEX_BITS  architectural destination per slot.
- retire_phys_reg  in  N x PRF_NUM_INDEX_BITS  physical register allocated at rename per slot.
- rrat_entries  out  RAT_SIZE x PRF_NUM_INDEX_BITS  committed map (registered).
- rrat_free_list  out  PRF_NUM_ENTRIES  committed free list, 1 = free (registered).
- free_vector_from_rrat  out  PRF_NUM_ENTRIES  one-cycle pulse of PRFs freed by last cycle's retirement.
- rrat_free_count  out  PRF_NUM_INDEX_BITS+1  popcount of rrat_free_list (registered).
- rrat_error  out  1  sticky consistency error (see Optional Feature).

Behaviour:
Reset (reset low, asynchronous):
- rrat_entries = all 0.
- rrat_free_list = all 1 except bit 0 = 0; PRF 0 is the permanent zero register.
- free_vector_from_rrat = 0.
- rrat_free_count = PRF_NUM_ENTRIES-1.
- rrat_error = 0.
- Reset asserted mid-operation discards all retirements of that cycle.

Slot qualification:
- Slot i is effective iff retire_valid[i] && retire_arch_reg[i] != 0.
- Ineffective slots change nothing.

Per-cycle update (all outputs registered, latency 1 edge):
- Walk slots in order 0..N-1 against a working copy of the map.
- For each effective slot:
  - old = working_map[arch].
  - working_map[arch] = phys.
  - Clear free bit [phys].
  - If old != 0: set free bit [old] and set pulse bit [old].
- Same-cycle same-arch chaining: if slots i<j hit the same arch reg, slot j's old is slot i's phys. Slot i's phys is therefore freed in the same cycle and pulsed; only slot j's mapping survives.
- Pulse output: free_vector_from_rrat <= pulse bits. It is zero in any cycle following a cycle with no effective freeing slot.
- The RAT samples the pulse combinationally, so frees reach the RAT free list 2 edges after retirement.
- rrat_free_count <= popcount of the next free list, computed in the same cycle (no extra lag).
- PRF 0 never enters the free list or the pulse vector, even if presented as old.
- No stall or handshake: retirement is unconditionally accepted every cycle. The ROB guarantees valid slots are in program order.

Optional Feature:
Macro RRAT_CHECK_EN.
- Defined: rrat_error sets (sticky until reset) on either of:
  - an effective slot whose retire_phys_reg is 0;
  - an effective slot whose retire_phys_reg is not currently free in rrat_free_list, when that register was not allocated by an earlier slot in the same cycle.
  - Checking against the pre-update free list includes the case where the phys is currently mapped.
  - The update still proceeds as normal.
- Undefined: no check logic; rrat_error tied 0.

Test Plan:
- Reset release, no retire: rrat_entries all 0, rrat_free_list = ~64'h1, rrat_free_count = 63, pulse = 0 for all cycles.
- Slot0 retires x5->p7: next edge rrat_entries[5]=7, free bit 7 = 0, count = 62, pulse = 0 (old was p0). Then x5->p9: rrat_entries[5]=9, pulse bit 7 for exactly one cycle, count stays 62.
- Same-cycle chain x3->p10 (slot0), x3->p11 (slot1), prior x3=p4: rrat_entries[3]=11, pulse = bits {4,10}, free bits 4 and 10 = 1, bit 11 = 0.
- Arch reg 0 retire x0->p12 with valid=1: no map, free, pulse, or count change.
- Full width, 3 slots retiring x1..x3 -> p20..p22 from reset state: count 63->60, pulse 0. Assert reset low mid-cycle: outputs return to reset values immediately, before the next edge.
- RRAT_CHECK_EN defined: retire x6->p7 while p7 is mapped to x5: rrat_error = 1 after the edge and stays 1 until reset; map still updates x6 = 7.
